// File: rtl/npc_mem_pkg.sv
// Shared types and constants for the NPC memory port: FSM states, owner IDs,
// write masks and the fetch start address.
package npc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  localparam logic [7:0]  WMASK_NONE = 8'h00;
  localparam logic [7:0]  WMASK_B    = 8'h01;
  localparam logic [7:0]  WMASK_W    = 8'h0F;
  localparam logic [31:0] RESET_PC   = 32'h8000_0000;

endpackage

// File: rtl/mem_port_arb_if.sv
// Bundle of the IFU, LSU and memory-side handshakes around the shared port.
// slave is the arbiter's view; master is the requesters-plus-memory view.
interface mem_port_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_resp_valid;
  logic [DATA_W-1:0] ifu_rdata;
  logic              ifu_resp_err;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_addr;
  logic              lsu_wen;
  logic [DATA_W-1:0] lsu_wdata;
  logic [7:0]        lsu_wmask;
  logic              lsu_resp_valid;
  logic [DATA_W-1:0] lsu_rdata;
  logic              lsu_resp_err;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [7:0]        mem_wmask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant: a lone requester always wins,
// a conflict goes to whichever side did not win last time.
module rr_arb2
  import npc_mem_pkg::*;
(
  input  logic   ifu_valid,
  input  logic   lsu_valid,
  input  owner_t last_grant,
  output logic   gnt_ifu,
  output logic   gnt_lsu
);

  always_comb begin
    gnt_ifu = 1'b0;
    gnt_lsu = 1'b0;
    if (ifu_valid && lsu_valid) begin
      gnt_ifu = (last_grant == OWN_LSU);
      gnt_lsu = (last_grant == OWN_IFU);
    end else begin
      gnt_ifu = ifu_valid;
      gnt_lsu = lsu_valid;
    end
  end

endmodule

// File: rtl/mem_port_arb.sv
// Shares the single memory port between fetch and load/store: one transaction
// at a time, round-robin on conflicts, error response if memory never answers.
module mem_port_arb
  import npc_mem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic           clk,
  input  logic           reset,
  mem_port_arb_if.slave  bus
);

  state_t            state, state_next;
  owner_t            owner_q, last_grant;
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0]        wmask_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [7:0]        tmo_cnt;

  logic gnt_ifu, gnt_lsu;
  logic accept, capture, timeout, tmo_hit, busy, busy_next;

  rr_arb2 u_rr_arb2 (
    .ifu_valid  (bus.ifu_req_valid),
    .lsu_valid  (bus.lsu_req_valid),
    .last_grant (last_grant),
    .gnt_ifu    (gnt_ifu),
    .gnt_lsu    (gnt_lsu)
  );

  assign accept    = (state == IDLE) && (gnt_ifu || gnt_lsu);
  assign tmo_hit   = (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
  assign busy      = (state == REQ) || (state == WAIT);
  assign busy_next = (state_next == REQ) || (state_next == WAIT);

  // A response in the same cycle as completion wins over the timeout.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: if (accept) state_next = REQ;
      REQ: begin
        if (bus.mem_req_ready && bus.mem_resp_valid) begin
          capture    = 1'b1;
          state_next = RESP;
        end else if (tmo_hit) begin
          timeout    = 1'b1;
          state_next = RESP;
        end else if (bus.mem_req_ready) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_resp_valid) begin
          capture    = 1'b1;
          state_next = RESP;
        end else if (tmo_hit) begin
          timeout    = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner_q    <= OWN_IFU;
      last_grant <= OWN_LSU;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= WMASK_NONE;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      state   <= state_next;
      tmo_cnt <= (busy && busy_next) ? tmo_cnt + 8'd1 : 8'd0;
      if (accept) begin
        owner_q    <= gnt_lsu ? OWN_LSU : OWN_IFU;
        last_grant <= gnt_lsu ? OWN_LSU : OWN_IFU;
        if (gnt_lsu) begin
          addr_q  <= bus.lsu_addr;
          wen_q   <= bus.lsu_wen;
          wdata_q <= bus.lsu_wdata;
          wmask_q <= bus.lsu_wen ? bus.lsu_wmask : WMASK_NONE;
        end else begin
          addr_q  <= bus.ifu_addr;
          wen_q   <= 1'b0;
          wdata_q <= '0;
          wmask_q <= WMASK_NONE;
        end
      end
      if (capture) begin
        rdata_q <= wen_q ? '0 : bus.mem_rdata;
        err_q   <= 1'b0;
      end else if (timeout) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  // Outputs are gated by state so nothing stale leaks outside REQ/RESP.
  assign bus.ifu_req_ready  = (state == IDLE) && gnt_ifu;
  assign bus.lsu_req_ready  = (state == IDLE) && gnt_lsu;

  assign bus.mem_req_valid  = (state == REQ);
  assign bus.mem_addr       = (state == REQ) ? addr_q  : '0;
  assign bus.mem_wen        = (state == REQ) ? wen_q   : 1'b0;
  assign bus.mem_wdata      = (state == REQ) ? wdata_q : '0;
  assign bus.mem_wmask      = (state == REQ) ? wmask_q : WMASK_NONE;

  assign bus.ifu_resp_valid = (state == RESP) && (owner_q == OWN_IFU);
  assign bus.lsu_resp_valid = (state == RESP) && (owner_q == OWN_LSU);
  assign bus.ifu_rdata      = bus.ifu_resp_valid ? rdata_q : '0;
  assign bus.lsu_rdata      = bus.lsu_resp_valid ? rdata_q : '0;
  assign bus.ifu_resp_err   = bus.ifu_resp_valid && err_q;
  assign bus.lsu_resp_err   = bus.lsu_resp_valid && err_q;

endmodule
